i2s_clkgen_tx: RTL and testbench
================================

I2S_CLKGEN_TX -- requirements
Module: i2s_clkgen_tx

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 9: clk50 cycles per bclk half-period (legal >= 1).
REQ-002 SHALL have parameter WORD_BITS, default 16: audio bits per channel (legal 1..SLOT_BITS-1).
REQ-003 SHALL have parameter SLOT_BITS, default 32: bclk periods per channel slot.
REQ-004 SHALL have parameter MODE, default 0: 0 = I2S (MSB one bclk after lrc edge), 1 = left-justified (MSB on lrc edge).
REQ-005 SHALL have port clk50, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-007 SHALL have port en, input, 1: run enable.
REQ-008 SHALL have port sample_l, input, WORD_BITS: left sample, two's complement.
REQ-009 SHALL have port sample_r, input, WORD_BITS: right sample.
REQ-010 SHALL have port sample_valid, input, 1: sample pair offered.
REQ-011 SHALL have port sample_ready, output, 1: holding buffer empty, i.e. ~full.
REQ-012 SHALL have port bclk, output, 1: bit clock, registered.
REQ-013 SHALL have port lrc, output, 1: frame clock, 0 = left slot, 1 = right slot, registered.
REQ-014 SHALL have port dacdat, output, 1: serial data, registered.
REQ-015 SHALL have port underrun, output, 1: one-cycle pulse.

Function
REQ-016 SHALL use two states, IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE on any cycle with en=0.
REQ-017 In IDLE, divider, bitcnt, bclk, lrc and dacdat SHALL be 0; the buffer SHALL still accept a pair.
REQ-018 In RUN, the divider SHALL count 0..BCLK_HALF-1, toggle bclk when it equals BCLK_HALF-1, and wrap to 0 on the same cycle.
REQ-019 A fall event SHALL be the cycle in which bclk toggles 1->0; bitcnt (width clog2(2*SLOT_BITS)) SHALL increment on each fall event, wrapping 2*SLOT_BITS-1 -> 0.
REQ-020 lrc SHALL be registered as (bitcnt >= SLOT_BITS); lrc and dacdat SHALL change only on fall events or on the IDLE->RUN cycle.
REQ-021 A frame-start SHALL be the IDLE->RUN cycle or the fall event where bitcnt wraps to 0.
REQ-022 At frame-start with buffer full, the pair SHALL move to the shift registers and full SHALL clear; with buffer empty, the shift registers SHALL load zeros and underrun SHALL pulse high for that cycle.
REQ-023 Within each slot at slot bit position p (0..SLOT_BITS-1), dacdat SHALL be data bit WORD_BITS-1-(p-MODE_OFS), where MODE_OFS = 1 for MODE 0 and 0 for MODE 1, when 0 <= p-MODE_OFS < WORD_BITS; otherwise 0.
REQ-024 Handshake: valid&ready on a rising edge SHALL capture sample_l/sample_r and set full; sample_valid while full SHALL be ignored and data SHALL NOT change.
REQ-025 Capture and an empty-buffer frame-start on the same cycle: that frame SHALL output zeros, underrun SHALL pulse, and the captured pair SHALL be held for the next frame-start.
REQ-026 Leaving RUN mid-frame SHALL abandon the frame; the buffer contents SHALL be kept.

Reset
REQ-027 While rst=1: state IDLE; divider, bitcnt and shift registers 0; bclk=0, lrc=0, dacdat=0, underrun=0, full=0 (so sample_ready=1).
REQ-028 After rst falls, the first IDLE->RUN transition SHALL be a frame-start.

Verification (defaults: bclk period 18 cycles, frame 1152 cycles)
REQ-029 Clock: en=1 held -> bclk rises 9 cycles after RUN entry; period 18; lrc period 1152, 50 % duty; 64 fall events per frame.
REQ-030 I2S data: pair L=16'hA5C3, R=16'h8001 loaded before en -> left MSB (1) on the 2nd left bclk period; 16 bits A5C3 MSB-first; zeros to slot end; right slot 8001 likewise.
REQ-031 MODE=1, same pair -> MSB coincides with lrc edge; bit 15 of each slot = LSB; positions 16..31 are 0.
REQ-032 Underrun: no pair offered, en=1 -> dacdat constant 0, underrun pulses exactly once per frame-start, bclk/lrc unaffected.
REQ-033 Handshake: valid held high continuously -> exactly one capture per frame (ready low from capture to next frame-start); a pair offered in the frame-start cycle with buffer empty -> underrun=1 and the pair is output in the following frame.
REQ-034 Disruption: en dropped at bitcnt=40 -> next cycle bclk=lrc=dacdat=0, buffered pair kept; rst asserted mid-frame -> all outputs 0 asynchronously, sample_ready=1.

Source files
------------

// File: rtl/i2s_clkgen_tx.sv
`default_nettype none
// ============================================================================
// Module      : i2s_clkgen_tx
// Description : I2S / left-justified audio transmitter. Derives bclk and lrc
//               from clk50 with an integer divider, serialises one buffered
//               stereo sample pair per frame MSB-first and flags underruns.
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_clkgen_tx #(
   parameter int BCLK_HALF = 9,
   parameter int WORD_BITS = 16,
   parameter int SLOT_BITS = 32,
   parameter int MODE      = 0
) (
   input  logic                 clk50,
   input  logic                 rst,
   input  logic                 en,
   input  logic [WORD_BITS-1:0] sample_l,
   input  logic [WORD_BITS-1:0] sample_r,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 bclk,
   output logic                 lrc,
   output logic                 dacdat,
   output logic                 underrun
);

   localparam int c_CNT_W    = $clog2(2 * SLOT_BITS);
   localparam int c_DIV_W    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam int c_MODE_OFS = (MODE == 0) ? 1 : 0;

   localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(BCLK_HALF - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(2 * SLOT_BITS - 1);
   localparam logic [c_CNT_W-1:0] c_SLOT    = c_CNT_W'(SLOT_BITS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t               r_state;
   logic [c_DIV_W-1:0]   r_div;
   logic [c_CNT_W-1:0]   r_bitcnt;
   logic                 r_bclk;
   logic                 r_lrc;
   logic                 r_dacdat;
   logic                 r_underrun;
   logic [WORD_BITS-1:0] r_sh_l;
   logic [WORD_BITS-1:0] r_sh_r;
   logic [WORD_BITS-1:0] r_buf_l;
   logic [WORD_BITS-1:0] r_buf_r;
   logic                 r_full;

   logic                 w_fall;
   logic                 w_wrap;
   logic                 w_frame_start;
   logic [c_CNT_W-1:0]   w_cnt_next;
   logic [WORD_BITS-1:0] w_sh_l_next;
   logic [WORD_BITS-1:0] w_sh_r_next;
   logic                 w_slot;
   logic [WORD_BITS-1:0] w_word;
   logic [WORD_BITS-1:0] w_shifted;
   int                   w_pos;
   logic                 w_dat;

   // A fall event is the divider terminal count while bclk is high; a frame
   // starts on RUN entry or when the bit counter wraps.
   assign w_fall        = (r_state == S_RUN) && en && r_bclk && (r_div == c_DIV_MAX);
   assign w_wrap        = w_fall && (r_bitcnt == c_CNT_MAX);
   assign w_frame_start = ((r_state == S_IDLE) && en) || w_wrap;

   assign sample_ready  = ~r_full;
   assign bclk          = r_bclk;
   assign lrc           = r_lrc;
   assign dacdat        = r_dacdat;
   assign underrun      = r_underrun;

   // Next bit position, next shift-register contents and the serial bit that
   // belongs to that position; the registers below only latch these.
   always_comb begin
      w_cnt_next  = r_bitcnt;
      w_sh_l_next = r_sh_l;
      w_sh_r_next = r_sh_r;
      w_shifted   = '0;
      w_dat       = 1'b0;
      if (w_frame_start) begin
         w_cnt_next  = '0;
         w_sh_l_next = r_full ? r_buf_l : '0;
         w_sh_r_next = r_full ? r_buf_r : '0;
      end else if (w_fall) begin
         w_cnt_next  = r_bitcnt + c_CNT_W'(1);
      end
      w_slot = (w_cnt_next >= c_SLOT);
      w_word = w_slot ? w_sh_r_next : w_sh_l_next;
      w_pos  = int'(w_cnt_next) - (w_slot ? SLOT_BITS : 0) - c_MODE_OFS;
      if ((w_pos >= 0) && (w_pos < WORD_BITS)) begin
         w_shifted = w_word >> (WORD_BITS - 1 - w_pos);
         w_dat     = w_shifted[0];
      end
   end

   // Run/idle control, bclk divider, bit counter and registered serial outputs.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_div      <= '0;
         r_bitcnt   <= '0;
         r_bclk     <= 1'b0;
         r_lrc      <= 1'b0;
         r_dacdat   <= 1'b0;
         r_underrun <= 1'b0;
         r_sh_l     <= '0;
         r_sh_r     <= '0;
      end else begin
         r_underrun <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_div    <= '0;
               r_bitcnt <= '0;
               r_bclk   <= 1'b0;
               r_lrc    <= 1'b0;
               r_dacdat <= 1'b0;
               if (en) begin
                  r_state    <= S_RUN;
                  r_sh_l     <= w_sh_l_next;
                  r_sh_r     <= w_sh_r_next;
                  r_lrc      <= w_slot;
                  r_dacdat   <= w_dat;
                  r_underrun <= ~r_full;
               end
            end
            S_RUN: begin
               if (!en) begin
                  // Abandon the frame; the holding buffer is left untouched.
                  r_state  <= S_IDLE;
                  r_div    <= '0;
                  r_bitcnt <= '0;
                  r_bclk   <= 1'b0;
                  r_lrc    <= 1'b0;
                  r_dacdat <= 1'b0;
               end else begin
                  if (r_div == c_DIV_MAX) begin
                     r_div  <= '0;
                     r_bclk <= ~r_bclk;
                  end else begin
                     r_div  <= r_div + c_DIV_W'(1);
                  end
                  if (w_fall) begin
                     r_bitcnt <= w_cnt_next;
                     r_lrc    <= w_slot;
                     r_dacdat <= w_dat;
                  end
                  r_sh_l     <= w_sh_l_next;
                  r_sh_r     <= w_sh_r_next;
                  r_underrun <= w_wrap & ~r_full;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // One-deep holding buffer: filled by the handshake, drained at frame start.
   always_ff @(posedge clk50 or posedge rst) begin
      if (rst) begin
         r_full  <= 1'b0;
         r_buf_l <= '0;
         r_buf_r <= '0;
      end else if (w_frame_start && r_full) begin
         r_full  <= 1'b0;
      end else if (sample_valid && !r_full) begin
         r_full  <= 1'b1;
         r_buf_l <= sample_l;
         r_buf_r <= sample_r;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_i2s_clkgen_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_clkgen_tx
// Description : Self-checking bench for i2s_clkgen_tx (MODE 0 and MODE 1
//               instances share stimulus; per-instance bit scoreboards).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_clkgen_tx;

   logic        clk50 = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] sample_l;
   logic [15:0] sample_r;
   logic        sample_valid;

   logic ready0, bclk0, lrc0, dacdat0, underrun0;
   logic ready1, bclk1, lrc1, dacdat1, underrun1;

   i2s_clkgen_tx #(.BCLK_HALF(9), .WORD_BITS(16), .SLOT_BITS(32), .MODE(0)) dut0 (
      .clk50(clk50), .rst(rst), .en(en),
      .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
      .sample_ready(ready0), .bclk(bclk0), .lrc(lrc0), .dacdat(dacdat0),
      .underrun(underrun0));

   i2s_clkgen_tx #(.BCLK_HALF(9), .WORD_BITS(16), .SLOT_BITS(32), .MODE(1)) dut1 (
      .clk50(clk50), .rst(rst), .en(en),
      .sample_l(sample_l), .sample_r(sample_r), .sample_valid(sample_valid),
      .sample_ready(ready1), .bclk(bclk1), .lrc(lrc1), .dacdat(dacdat1),
      .underrun(underrun1));

   always #5 clk50 = ~clk50;

   int checks = 0;
   int errors = 0;
   int k;
   int ur0, ur1, rdy_hi;
   logic pb0 = 1'b0, pb1 = 1'b0, pl0 = 1'b0;
   logic [1:0] q0[$];
   logic [1:0] q1[$];
   int rise_k[$];
   int lrc_rise_k[$];
   int lrc_fall_k[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [15:0] w, input int p, input int ofs);
      logic [15:0] t;
      int q;
      q = p - ofs;
      if (q < 0 || q >= 16) return 1'b0;
      t = w >> (15 - q);
      return t[0];
   endfunction

   // Expected {lrc, dacdat} at each bclk rise for the first npos bit positions.
   task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input int npos);
      for (int c = 0; c < npos; c++) begin
         logic slot;
         logic [15:0] w;
         slot = (c >= 32);
         w    = slot ? r : l;
         q0.push_back({slot, exp_bit(w, c % 32, 1)});
         q1.push_back({slot, exp_bit(w, c % 32, 0)});
      end
   endtask

   task automatic step();
      logic [1:0] e;
      @(negedge clk50);
      k++;
      if (bclk0 && !pb0) begin
         rise_k.push_back(k);
         if (q0.size() == 0) check($sformatf("sb0_extra_bit k=%0d", k), 32'(q0.size()), 1);
         else begin
            e = q0.pop_front();
            check($sformatf("m0_lrc_dat k=%0d", k), 32'({lrc0, dacdat0}), 32'(e));
         end
      end
      if (bclk1 && !pb1) begin
         if (q1.size() == 0) check($sformatf("sb1_extra_bit k=%0d", k), 32'(q1.size()), 1);
         else begin
            e = q1.pop_front();
            check($sformatf("m1_lrc_dat k=%0d", k), 32'({lrc1, dacdat1}), 32'(e));
         end
      end
      if (lrc0 && !pl0) lrc_rise_k.push_back(k);
      if (!lrc0 && pl0) lrc_fall_k.push_back(k);
      if (underrun0) ur0++;
      if (underrun1) ur1++;
      if (ready0) rdy_hi++;
      pb0 = bclk0;
      pb1 = bclk1;
      pl0 = lrc0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic begin_phase();
      k = 0; ur0 = 0; ur1 = 0; rdy_hi = 0;
      rise_k.delete(); lrc_rise_k.delete(); lrc_fall_k.delete();
   endtask

   task automatic end_phase(input string name, input int exp_ur);
      check({name, "_sb0_left"}, 32'(q0.size()), 0);
      check({name, "_sb1_left"}, 32'(q1.size()), 0);
      check({name, "_underruns0"}, 32'(ur0), 32'(exp_ur));
      check({name, "_underruns1"}, 32'(ur1), 32'(exp_ur));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_l = '0; sample_r = '0;
      repeat (3) @(negedge clk50);
      // Reset state
      check("rst_bclk", 32'(bclk0), 0);
      check("rst_lrc", 32'(lrc0), 0);
      check("rst_dacdat", 32'(dacdat0), 0);
      check("rst_underrun", 32'(underrun0), 0);
      check("rst_ready0", 32'(ready0), 1);
      check("rst_ready1", 32'(ready1), 1);
      rst = 1'b0;

      // I2S / left-justified data with pair loaded in IDLE; second offer ignored
      sample_l = 16'hA5C3; sample_r = 16'h8001; sample_valid = 1'b1;
      step();
      check("idle_capture_ready", 32'(ready0), 0);
      sample_l = 16'hB0B0; sample_r = 16'h1111;
      step();
      sample_valid = 1'b0;
      check("full_ignore_ready", 32'(ready0), 0);
      begin_phase();
      push_frame(16'hA5C3, 16'h8001, 64);
      push_frame(16'h0000, 16'h0000, 64);
      en = 1'b1;
      run(2300);
      check("bclk_first_rise", 32'(rise_k.size() > 0 ? rise_k[0] : -1), 10);
      check("bclk_second_rise", 32'(rise_k.size() > 1 ? rise_k[1] : -1), 28);
      check("bclk_rises_2frames", 32'(rise_k.size()), 128);
      check("lrc_rise", 32'(lrc_rise_k.size() > 0 ? lrc_rise_k[0] : -1), 577);
      check("lrc_fall", 32'(lrc_fall_k.size() > 0 ? lrc_fall_k[0] : -1), 1153);
      end_phase("p2", 1);
      en = 1'b0;
      step();
      check("stop_bclk", 32'(bclk0), 0);
      check("stop_lrc", 32'(lrc0), 0);

      // Valid held continuously: one capture per frame, later data ignored
      sample_valid = 1'b1; sample_l = 16'h1234; sample_r = 16'h5678;
      step();
      sample_l = 16'h9ABC; sample_r = 16'hDEF0;
      begin_phase();
      push_frame(16'h1234, 16'h5678, 64);
      push_frame(16'h9ABC, 16'hDEF0, 64);
      en = 1'b1;
      run(20);
      sample_l = 16'h0F0F; sample_r = 16'hF1F0;
      run(2280);
      sample_valid = 1'b0;
      check("p3_ready_high_cycles", 32'(rdy_hi), 2);
      end_phase("p3", 0);
      en = 1'b0;
      step();
      check("p3_buffer_kept_ready", 32'(ready0), 0);

      // Drop en at bitcnt 40: frame abandoned, buffered pair kept
      begin_phase();
      push_frame(16'h0F0F, 16'hF1F0, 41);
      en = 1'b1;
      run(3);
      sample_l = 16'h1111; sample_r = 16'h2222; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      run(731);
      en = 1'b0;
      step();
      check("drop_bclk", 32'(bclk0), 0);
      check("drop_lrc", 32'(lrc0), 0);
      check("drop_dacdat0", 32'(dacdat0), 0);
      check("drop_dacdat1", 32'(dacdat1), 0);
      check("drop_ready", 32'(ready0), 0);
      end_phase("p4a", 0);

      // Kept pair output; capture coinciding with empty frame start
      begin_phase();
      push_frame(16'h1111, 16'h2222, 64);
      push_frame(16'h0000, 16'h0000, 64);
      push_frame(16'h3333, 16'h4444, 64);
      en = 1'b1;
      run(1152);
      sample_l = 16'h3333; sample_r = 16'h4444; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      check("coincide_underrun", 32'(underrun0), 1);
      check("coincide_ready", 32'(ready0), 0);
      run(2299);
      end_phase("p4b", 1);

      // Asynchronous reset mid-frame with a full buffer
      en = 1'b0;
      step();
      sample_l = 16'h5555; sample_r = 16'h6666; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      begin_phase();
      push_frame(16'h5555, 16'h6666, 3);
      en = 1'b1;
      run(50);
      sample_l = 16'h7777; sample_r = 16'h8888; sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      run(3);
      check("pre_rst_ready", 32'(ready0), 0);
      end_phase("p5", 0);
      #2 rst = 1'b1;
      #1;
      check("arst_bclk", 32'(bclk0), 0);
      check("arst_lrc", 32'(lrc0), 0);
      check("arst_dacdat", 32'(dacdat0 | dacdat1), 0);
      check("arst_underrun", 32'(underrun0), 0);
      check("arst_ready", 32'(ready0), 1);
      en = 1'b0;
      @(negedge clk50);
      rst = 1'b0;

      // First RUN entry after reset is a frame start (empty buffer -> underrun)
      begin_phase();
      push_frame(16'h0000, 16'h0000, 3);
      en = 1'b1;
      run(50);
      check("post_rst_first_rise", 32'(rise_k.size() > 0 ? rise_k[0] : -1), 10);
      end_phase("p6", 1);
      en = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
